// File: rtl/audio_gain_ramp_pkg.sv
// Shared constants and FSM encoding for the stereo gain-ramp sample mover.
// Default widths, unity gain and the state type used by the top and the bench.
package audio_gain_ramp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_GAIN_WIDTH = 8;
  localparam int DEF_GAIN_FRAC  = 6;
  localparam int DEF_RAMP_STEP  = 1;
  localparam int GAIN_UNITY     = 1 << DEF_GAIN_FRAC;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_LAT  = 3'd2,
    ST_MUL  = 3'd3,
    ST_WR   = 3'd4
  } state_t;

endpackage

// File: rtl/audio_gain_ramp_if.sv
// FIFO-side bundle for the gain-ramp mover: RX FIFO read port plus TX FIFO write port.
// Handshake: read/write are single-cycle strobes issued only when empty/full are low;
// readdata is valid the cycle after read, writedata is valid while write is high.
interface audio_gain_ramp_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  adcfifo_empty;
  logic                  adcfifo_read;
  logic [DATA_WIDTH-1:0] adcfifo_readdata;
  logic                  dacfifo_full;
  logic                  dacfifo_write;
  logic [DATA_WIDTH-1:0] dacfifo_writedata;

  modport master (
    input  adcfifo_empty,
    input  adcfifo_readdata,
    input  dacfifo_full,
    output adcfifo_read,
    output dacfifo_write,
    output dacfifo_writedata
  );

  modport slave (
    output adcfifo_empty,
    output adcfifo_readdata,
    output dacfifo_full,
    input  adcfifo_read,
    input  dacfifo_write,
    input  dacfifo_writedata
  );

endinterface

// File: rtl/audio_gain_ramp_sat_mul.sv
// One channel of the gain stage: signed sample times unsigned fixed-point gain,
// arithmetic shift (floor), then saturation to the sample width with a clip flag.
module audio_gain_ramp_sat_mul #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int GAIN_FRAC    = 6
) (
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [GAIN_WIDTH-1:0]   gain,
  output logic [SAMPLE_WIDTH-1:0] result,
  output logic                    clip
);

  localparam int PW = SAMPLE_WIDTH + GAIN_WIDTH + 1;

  localparam logic signed [PW-1:0] SAT_MAX =
    {{(PW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [PW-1:0] sample_ext;
  logic signed [PW-1:0] gain_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;

  // PW bits hold the full signed product, so nothing is lost before saturation.
  assign sample_ext = {{(PW-SAMPLE_WIDTH){sample[SAMPLE_WIDTH-1]}}, sample};
  assign gain_ext   = {{(PW-GAIN_WIDTH){1'b0}}, gain};
  assign prod       = sample_ext * gain_ext;
  assign shifted    = prod >>> GAIN_FRAC;

  always_comb begin
    result = shifted[SAMPLE_WIDTH-1:0];
    clip   = 1'b0;
    if (shifted > SAT_MAX) begin
      result = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
      clip   = 1'b1;
    end else if (shifted < SAT_MIN) begin
      result = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
      clip   = 1'b1;
    end
  end

endmodule

// File: rtl/audio_gain_ramp.sv
// Moves stereo samples RX FIFO -> gain/saturate -> TX FIFO, one sample in flight at a time,
// ramping the applied gain one step per pushed sample toward target (or 0 when muted).
module audio_gain_ramp
  import audio_gain_ramp_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
  parameter int GAIN_FRAC  = DEF_GAIN_FRAC,
  parameter int RAMP_STEP  = DEF_RAMP_STEP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  audio_gain_ramp_if.master     fifo,
  input  logic [GAIN_WIDTH-1:0] target_gain,
  input  logic                  mute,
  output logic [GAIN_WIDTH-1:0] cur_gain,
  output logic                  clip,
  output state_t                state
);

  localparam int CW = DATA_WIDTH / 2;
  localparam logic [GAIN_WIDTH-1:0] STEP = GAIN_WIDTH'(RAMP_STEP);

  state_t                  state_q;
  state_t                  state_d;
  logic [DATA_WIDTH-1:0]   in_q;
  logic [DATA_WIDTH-1:0]   out_q;
  logic                    clip_q;
  logic [GAIN_WIDTH-1:0]   gain_q;
  logic [GAIN_WIDTH-1:0]   gain_d;
  logic [GAIN_WIDTH-1:0]   tgt;
  logic [CW-1:0]           res0;
  logic [CW-1:0]           res1;
  logic                    clip0;
  logic                    clip1;
  logic                    push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!fifo.adcfifo_empty) state_d = ST_RD;
      ST_RD:   state_d = ST_LAT;
      ST_LAT:  state_d = ST_MUL;
      ST_MUL:  state_d = ST_WR;
      ST_WR:   if (!fifo.dacfifo_full) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fifo.adcfifo_read  = 1'b0;
    fifo.dacfifo_write = 1'b0;
    push               = 1'b0;
    case (state_q)
      ST_RD: fifo.adcfifo_read = 1'b1;
      ST_WR: begin
        push               = !fifo.dacfifo_full;
        fifo.dacfifo_write = !fifo.dacfifo_full;
      end
      default: ;
    endcase
  end

  audio_gain_ramp_sat_mul #(
    .SAMPLE_WIDTH (CW),
    .GAIN_WIDTH   (GAIN_WIDTH),
    .GAIN_FRAC    (GAIN_FRAC)
  ) u_mul_ch0 (
    .sample (in_q[CW-1:0]),
    .gain   (gain_q),
    .result (res0),
    .clip   (clip0)
  );

  audio_gain_ramp_sat_mul #(
    .SAMPLE_WIDTH (CW),
    .GAIN_WIDTH   (GAIN_WIDTH),
    .GAIN_FRAC    (GAIN_FRAC)
  ) u_mul_ch1 (
    .sample (in_q[DATA_WIDTH-1:CW]),
    .gain   (gain_q),
    .result (res1),
    .clip   (clip1)
  );

  // Step toward the target without overshooting; comparing the gap avoids wrap.
  always_comb begin
    tgt    = mute ? '0 : target_gain;
    gain_d = gain_q;
    if (gain_q < tgt)      gain_d = ((tgt - gain_q) > STEP) ? gain_q + STEP : tgt;
    else if (gain_q > tgt) gain_d = ((gain_q - tgt) > STEP) ? gain_q - STEP : tgt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q   <= '0;
      out_q  <= '0;
      clip_q <= 1'b0;
      gain_q <= '0;
    end else begin
      if (state_q == ST_LAT) in_q <= fifo.adcfifo_readdata;
      if (state_q == ST_MUL) begin
        out_q  <= {res1, res0};
        clip_q <= clip0 | clip1;
      end
      if (push) gain_q <= gain_d;
    end
  end

  assign fifo.dacfifo_writedata = out_q;
  assign clip                   = clip_q & push;
  assign cur_gain               = gain_q;
  assign state                  = state_q;

endmodule

// File: tb/tb_audio_gain_ramp.sv
// Directed bench for audio_gain_ramp: hand-computed expectations go into a queue when a
// sample is fed; a negedge process models the RX FIFO and checks every TX push.
module tb_audio_gain_ramp;
  import audio_gain_ramp_pkg::*;

  localparam int DW = 32;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [GW-1:0] target_gain;
  logic          mute;
  logic [GW-1:0] cur_gain;
  logic          clip;
  state_t        state;

  audio_gain_ramp_if #(.DATA_WIDTH(DW)) fifo ();

  audio_gain_ramp #(
    .DATA_WIDTH (DW),
    .GAIN_WIDTH (GW),
    .GAIN_FRAC  (6),
    .RAMP_STEP  (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fifo        (fifo.master),
    .target_gain (target_gain),
    .mute        (mute),
    .cur_gain    (cur_gain),
    .clip        (clip),
    .state       (state)
  );

  always #5 clk = ~clk;

  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              push_count = 0;
  int              last_read_cyc = 0;
  int              outstanding = 0;
  bit              lat_chk = 1'b1;
  logic [DW:0]     exp_q[$];
  logic [DW-1:0]   rx_q[$];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RX FIFO model plus TX monitor, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [DW:0] e;
    if (!reset_n) begin
      outstanding = 0;
    end else begin
      if (fifo.adcfifo_read) begin
        check("pop_nonempty", rx_q.size() != 0, 1);
        check("pop_in_flight", outstanding, 0);
        outstanding++;
        last_read_cyc = cyc;
        if (rx_q.size() != 0) fifo.adcfifo_readdata = rx_q.pop_front();
      end
      if (fifo.dacfifo_write) begin
        check("push_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("writedata", fifo.dacfifo_writedata, e[DW-1:0]);
          check("clip", clip, e[DW]);
        end
        if (lat_chk) check("latency", cyc - last_read_cyc, 3);
        outstanding--;
        push_count++;
      end
    end
    fifo.adcfifo_empty = (rx_q.size() == 0);
  end

  task automatic wait_push(input int start, input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (push_count > start) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_push_seen"}, done, 1);
  endtask

  task automatic wait_wr(input string tag);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (state == ST_WR) break;
    end
    check({tag, "_reach_wr"}, state, ST_WR);
  endtask

  task automatic feed(input logic [DW-1:0] word, input logic [DW-1:0] exp_word,
                      input logic exp_clip, input logic [GW-1:0] exp_gain, input string tag);
    int start;
    start = push_count;
    exp_q.push_back({exp_clip, exp_word});
    rx_q.push_back(word);
    wait_push(start, tag);
    check({tag, "_gain"}, cur_gain, exp_gain);
  endtask

  initial begin
    logic [15:0] ch;
    int          gb;
    int          ga;
    int          start;

    target_gain       = 8'd64;
    mute              = 1'b0;
    fifo.dacfifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cur_gain", cur_gain, 0);
    check("rst_write", fifo.dacfifo_write, 0);
    check("rst_read", fifo.adcfifo_read, 0);
    check("rst_writedata", fifo.dacfifo_writedata, 0);
    check("rst_clip", clip, 0);
    check("rst_state", state, ST_IDLE);
    reset_n = 1'b1;

    // T1: fade-in from gain 0 to unity on a constant 0x1000 per channel.
    for (int k = 1; k <= 66; k++) begin
      ch = (k <= 65) ? 16'(64 * (k - 1)) : 16'h1000;
      feed(32'h1000_1000, {ch, ch}, 1'b0, GW'((k > 64) ? 64 : k), "t1");
    end

    // T2: unity gain passes full-scale extremes untouched.
    feed(32'h8000_7FFF, 32'h8000_7FFF, 1'b0, 8'd64, "t2");

    // T5: mute ramps down to 0 and holds, unmute ramps back to 64.
    mute = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      gb = (65 - k > 0) ? 65 - k : 0;
      ga = (64 - k > 0) ? 64 - k : 0;
      ch = 16'(64 * gb);
      feed(32'h1000_1000, {ch, ch}, 1'b0, GW'(ga), "t5_down");
    end
    mute = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      ch = 16'(64 * (k - 1));
      feed(32'h1000_1000, {ch, ch}, 1'b0, GW'(k), "t5_up");
    end

    // T3: ramp to 2x with +/-64 inputs (output +/-g), then saturation corners.
    target_gain = 8'd128;
    for (int g = 64; g < 128; g++) begin
      feed(32'h0040_FFC0, {16'(g), 16'(-g)}, 1'b0, GW'(g + 1), "t3_ramp");
    end
    feed(32'h0000_4000, 32'h0000_7FFF, 1'b1, 8'd128, "t3_pos_sat");
    feed(32'h0000_C000, 32'h0000_8000, 1'b0, 8'd128, "t3_neg_edge");
    feed(32'h0000_BFFF, 32'h0000_8000, 1'b1, 8'd128, "t3_neg_sat");
    feed(32'h4000_0000, 32'h7FFF_0000, 1'b1, 8'd128, "t3_ch1_sat");
    feed(32'hC001_0100, 32'h8002_0200, 1'b0, 8'd128, "t3_mixed");

    // T4: hold in WR under backpressure while another sample waits in RX.
    lat_chk = 1'b0;
    fifo.dacfifo_full = 1'b1;
    exp_q.push_back({1'b0, 32'h0200_FE00});
    rx_q.push_back(32'h0100_FF00);
    wait_wr("t4");
    exp_q.push_back({1'b0, 32'h0000_0080});
    rx_q.push_back(32'h0000_0040);
    start = push_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_write", fifo.dacfifo_write, 0);
      check("t4_hold_read", fifo.adcfifo_read, 0);
      check("t4_hold_data", fifo.dacfifo_writedata, 32'h0200_FE00);
    end
    check("t4_no_push_while_full", push_count, start);
    fifo.dacfifo_full = 1'b0;
    wait_push(start, "t4_release");
    check("t4_single_push", push_count, start + 1);
    lat_chk = 1'b1;
    wait_push(start + 1, "t4_next");
    check("t4_gain", cur_gain, 8'd128);

    // T6: async reset while stalled in WR abandons the sample and zeroes the gain.
    lat_chk = 1'b0;
    fifo.dacfifo_full = 1'b1;
    rx_q.push_back(32'h1000_1000);
    wait_wr("t6");
    start = push_count;
    reset_n = 1'b0;
    #1;
    check("t6_write", fifo.dacfifo_write, 0);
    check("t6_read", fifo.adcfifo_read, 0);
    check("t6_writedata", fifo.dacfifo_writedata, 0);
    check("t6_clip", clip, 0);
    check("t6_cur_gain", cur_gain, 0);
    check("t6_state", state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1;
    check("t6_no_push", push_count, start);
    target_gain       = 8'd64;
    fifo.dacfifo_full = 1'b0;
    reset_n           = 1'b1;
    lat_chk           = 1'b1;
    feed(32'h1000_1000, 32'h0000_0000, 1'b0, 8'd1, "t6_resume0");
    feed(32'h1000_1000, 32'h0040_0040, 1'b0, 8'd2, "t6_resume1");

    repeat (4) @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
